// File: rtl/image_resize_bilinear_hsrc_pkg.sv
// Shared constants and FSM encoding for the horizontal bilinear source-fetch stage.
package image_resize_bilinear_hsrc_pkg;

    localparam int          FRAC_W     = 8;
    localparam int          PIX_W      = 24;
    localparam logic [8:0]  WEIGHT_ONE = 9'd256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_GEN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/image_resize_line_ram.sv
// One-line pixel buffer: one write port and two independent registered read ports,
// built as two mirrored simple-dual-port arrays that share the write.
module image_resize_line_ram
    import image_resize_bilinear_hsrc_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [PIX_W-1:0]  wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr0_i,
    input  logic [ADDR_W-1:0] rd_addr1_i,
    output logic [PIX_W-1:0]  rd_data0_o,
    output logic [PIX_W-1:0]  rd_data1_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [PIX_W-1:0] r_mem0 [DEPTH];
    logic [PIX_W-1:0] r_mem1 [DEPTH];

    // Mirror every write into both arrays so each read port owns a copy.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            r_mem0[wr_addr_i] <= wr_data_i;
            r_mem1[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered reads; data holds when no read is issued.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data0_o <= '0;
            rd_data1_o <= '0;
        end else if (rd_en_i) begin
            rd_data0_o <= r_mem0[rd_addr0_i];
            rd_data1_o <= r_mem1[rd_addr1_i];
        end
    end

endmodule

// File: rtl/image_resize_bilinear_hsrc.sv
// Horizontal source fetch for bilinear resize: buffers one RGB888 line, then steps a
// Q.8 source coordinate per output pixel and emits the neighbour pair plus weights.
module image_resize_bilinear_hsrc
    import image_resize_bilinear_hsrc_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W:0]          in_width_i,
    input  logic [ADDR_W:0]          out_width_i,
    input  logic [ADDR_W+FRAC_W-1:0] step_i,
    input  logic                     pix_valid_i,
    input  logic [PIX_W-1:0]         pix_data_i,
    output logic                     pix_ready_o,
    output logic                     valid_o,
    output logic [PIX_W-1:0]         data0_o,
    output logic [PIX_W-1:0]         data1_o,
    output logic [8:0]               weight0_o,
    output logic [8:0]               weight1_o,
    output logic                     last_o,
    output logic                     busy_o
);

    // One extra accumulator bit so overshoot past the line end cannot wrap to 0.
    localparam int ACC_W = ADDR_W + FRAC_W + 1;

    state_t                     r_state, w_state_nxt;
    logic                       r_rst_done;
    logic [ADDR_W:0]            r_in_w, r_out_w, r_out_cnt;
    logic [ADDR_W+FRAC_W-1:0]   r_step;
    logic [ADDR_W-1:0]          r_wr_addr;
    logic [ACC_W-1:0]           r_acc;
    logic                       r_valid, r_last;
    logic [8:0]                 r_weight0, r_weight1;

    logic                       w_accept, w_cfg_ok, w_gen, w_gen_done;
    logic [ADDR_W-1:0]          w_ram_waddr;
    logic [ADDR_W:0]            w_last_idx, w_idx, w_idx0, w_idx1;
    logic [FRAC_W-1:0]          w_frac;

    assign w_cfg_ok    = (in_width_i != '0) && (out_width_i != '0);
    assign w_gen       = (r_state == ST_GEN);
    assign w_gen_done  = (r_out_cnt == r_out_w - 1'b1);
    assign w_last_idx  = r_in_w - 1'b1;
    assign w_idx       = r_acc[ACC_W-1:FRAC_W];
    assign w_frac      = r_acc[FRAC_W-1:0];
    assign w_idx0      = (w_idx > w_last_idx) ? w_last_idx : w_idx;
    assign w_idx1      = (w_idx0 < w_last_idx) ? (w_idx0 + 1'b1) : w_last_idx;
    assign w_ram_waddr = (r_state == ST_IDLE) ? '0 : r_wr_addr;
    assign busy_o      = (r_state == ST_FILL) || (r_state == ST_GEN);

    // Next-state, input handshake and accept decode.
    always_comb begin
        w_state_nxt = r_state;
        pix_ready_o = 1'b0;
        case (r_state)
            ST_IDLE:  pix_ready_o = r_rst_done && w_cfg_ok;
            ST_FILL:  pix_ready_o = 1'b1;
            default:  pix_ready_o = 1'b0;
        endcase
        w_accept = pix_valid_i && pix_ready_o;
        case (r_state)
            ST_IDLE: begin
                if (w_accept)
                    w_state_nxt = (in_width_i == (ADDR_W+1)'(1)) ? ST_GEN : ST_FILL;
            end
            ST_FILL: begin
                if (w_accept && (r_wr_addr == w_last_idx[ADDR_W-1:0]))
                    w_state_nxt = ST_GEN;
            end
            ST_GEN: begin
                if (w_gen_done)
                    w_state_nxt = ST_DRAIN;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register; r_rst_done keeps the input closed until the first clock after reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= ST_IDLE;
            r_rst_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_rst_done <= 1'b1;
        end
    end

    // Shadow config latch, write address and coordinate stepping.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_in_w    <= '0;
            r_out_w   <= '0;
            r_step    <= '0;
            r_wr_addr <= '0;
            r_acc     <= '0;
            r_out_cnt <= '0;
        end else if ((r_state == ST_IDLE) && w_accept) begin
            r_in_w    <= in_width_i;
            r_out_w   <= out_width_i;
            r_step    <= step_i;
            r_wr_addr <= ADDR_W'(1);
            r_acc     <= '0;
            r_out_cnt <= '0;
        end else if ((r_state == ST_FILL) && w_accept) begin
            r_wr_addr <= r_wr_addr + 1'b1;
        end else if (w_gen) begin
            r_acc     <= r_acc + {1'b0, r_step};
            r_out_cnt <= r_out_cnt + 1'b1;
        end
    end

    // Output control and weights, aligned with the RAM read latency.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid   <= 1'b0;
            r_last    <= 1'b0;
            r_weight0 <= '0;
            r_weight1 <= '0;
        end else begin
            r_valid <= w_gen;
            r_last  <= w_gen && w_gen_done;
            if (w_gen) begin
                r_weight0 <= WEIGHT_ONE - {1'b0, w_frac};
                r_weight1 <= {1'b0, w_frac};
            end
        end
    end

    image_resize_line_ram #(
        .ADDR_W (ADDR_W)
    ) u_line_ram (
        .clk        (clk),
        .reset_n    (reset_n),
        .wr_en_i    (w_accept),
        .wr_addr_i  (w_ram_waddr),
        .wr_data_i  (pix_data_i),
        .rd_en_i    (w_gen),
        .rd_addr0_i (w_idx0[ADDR_W-1:0]),
        .rd_addr1_i (w_idx1[ADDR_W-1:0]),
        .rd_data0_o (data0_o),
        .rd_data1_o (data1_o)
    );

    assign valid_o   = r_valid;
    assign last_o    = r_last;
    assign weight0_o = r_weight0;
    assign weight1_o = r_weight1;

endmodule

// File: doc/image_resize_bilinear_hsrc.md
Name: image_resize_bilinear_hsrc

Overview:
Horizontal source-fetch stage that feeds the bilinear interpolation pipe.
- Buffers one input line of RGB888 pixels.
- Steps a Q.8 fixed-point source coordinate once per output pixel.
- Emits, per output pixel, the two neighbouring source pixels and the 9-bit weight pair that the downstream interpolator consumes. The weights always sum to 256.
- Sits between the pixel stream input and the bilinear calc stage.
- The downstream stage has no backpressure, so this block throttles only its input side.

Parameters:
ADDR_W, 10, line-buffer address width; max input width = 2^ADDR_W pixels
FRAC_W, 8, fractional bits of the coordinate step (fixed; weights are 9-bit)

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
in_width_i  in  ADDR_W+1  source line width in pixels, 1..2^ADDR_W
out_width_i  in  ADDR_W+1  output line width in pixels, 1..2^ADDR_W
step_i  in  ADDR_W+FRAC_W  source increment per output pixel, Q(ADDR_W).8 (= in_width*256/out_width, precomputed by software)
pix_valid_i  in  1  input pixel valid
pix_data_i  in  24  input pixel {R,G,B}
pix_ready_o  out  1  input pixel accepted when pix_valid_i & pix_ready_o
valid_o  out  1  output pair valid
data0_o  out  24  left source pixel
data1_o  out  24  right source pixel
weight0_o  out  9  weight for data0_o, 256-frac
weight1_o  out  9  weight for data1_o, frac
last_o  out  1  high with the final output pixel of a line
busy_o  out  1  high in FILL or GEN

Behaviour:
Reset:
- Async assert clears FSM to IDLE, counters, accumulator, and all outputs to 0.
- pix_ready_o is 0 while reset_n is low.
- Reset mid-FILL or mid-GEN abandons the line; no further valid_o until a new line completes FILL.

FSM states are IDLE, FILL, GEN, DRAIN.

IDLE:
- pix_ready_o=1 if in_width_i!=0 and out_width_i!=0, else 0.
- The first accepted pixel latches in_width_i, out_width_i and step_i into shadow registers, writes address 0, and moves to FILL. If in_width=1, that first pixel moves directly to GEN.
- Config changes after latching are ignored until the next line.

FILL:
- pix_ready_o=1; each accepted pixel is written at wr_addr, then wr_addr increments.
- Acceptance of pixel in_width-1 moves to GEN.
- pix_valid_i low simply stalls.

GEN:
- pix_ready_o=0; one read issued per cycle, with no bubbles.
- acc starts at 0; idx = acc[ADDR_W+7:8], frac = acc[7:0].
- idx is clamped to in_width-1; idx1 = min(idx+1, in_width-1).
- Reads buf[idx] and buf[idx1] are issued; acc += step; out_cnt increments.
- After out_width reads, move to DRAIN.

DRAIN:
- Lasts one cycle while the final read data emerges, then returns to IDLE (pix_ready_o rises).

Output timing and widths:
- Latency: read issued in cycle N produces valid_o=1 with data/weights in cycle N+1. Outputs are registered.
- valid_o is high for exactly out_width consecutive cycles per line.
- last_o is coincident with the out_width-th valid.
- weight0_o = 9'd256 - frac, so frac=0 gives 256/0. weight1_o = {1'b0,frac}.
- The accumulator is ADDR_W+FRAC_W+1 bits wide so overshoot cannot wrap; clamping covers overshoot.
- When valid_o=0, data and weights hold their last values. Only valid_o and last_o are guaranteed 0.

Decomposition:
- Shared package: FRAC_W, WEIGHT_ONE (9'd256), RGB pixel width (24), and the FSM state encoding.
- One sub-module: image_resize_line_ram, with 1 write port, 2 independent registered read ports, and depth 2^ADDR_W × 24. It may be implemented as two mirrored simple-dual-port RAMs.

Test Plan:
- 1:1: in_width=4, out_width=4, step=0x100, pixels P0..P3 → 4 valids with data0/data1 = (P0,P1),(P1,P2),(P2,P3),(P3,P3); weights 256/0 each; last_o on the 4th.
- 2× up: in_width=4, out_width=8, step=0x080 → pairs (P0,P1)256/0, (P0,P1)128/128, (P1,P2)256/0, …, (P3,P3)128/128; last_o on the 8th; valid_o contiguous 8 cycles.
- 2× down: in_width=8, out_width=4, step=0x200 → data0 = P0,P2,P4,P6; data1 = P1,P3,P5,P7; weights 256/0.
- Throttled input: pix_valid_i toggled every other cycle during FILL → all 4 pixels stored correctly; pix_ready_o=0 throughout GEN/DRAIN; a pixel presented during GEN is not accepted and is held by the source.
- Config guard: in_width=0 → pix_ready_o stays 0. Changing step_i during GEN has no effect on the current line.
- Reset mid-GEN: reset_n pulsed low after 2 of 8 outputs → valid_o=0 immediately (async), pix_ready_o=1 one cycle after release. The next full line produces exactly out_width outputs.
